// File: rtl/div_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_arb_pkg
// Purpose  : Default widths, divider latency and the in-flight tag type for
//            the divider arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package div_arb_pkg;

    localparam int c_num_req_def = 4;
    localparam int c_latency_def = 8;
    localparam int c_z_w_def     = 28;
    localparam int c_d_w_def     = 20;
    localparam int c_q_w_def     = 8;
    // Sized for the largest supported requester count (8).
    localparam int c_id_w        = 3;

    typedef struct packed {
        logic              valid;
        logic [c_id_w-1:0] id;
        logic              div0;
        logic              ovf;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/div_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter_if
// Purpose  : Requester, response and divider-side signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface div_arbiter_if
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ = c_num_req_def,
    parameter int Z_W     = c_z_w_def,
    parameter int D_W     = c_d_w_def,
    parameter int Q_W     = c_q_w_def
) ();

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*Z_W-1:0] req_divided;
    logic [NUM_REQ*D_W-1:0] req_divisor;
    logic                   hold;
    logic                   div_start;
    logic [Z_W-1:0]         div_divided;
    logic [D_W-1:0]         div_divisor;
    logic [Q_W-1:0]         div_q;
    logic                   div_start_out;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [Q_W-1:0]         rsp_q;
    logic                   rsp_div0;
    logic                   rsp_ovf;
    logic                   err;

    modport slave (
        input  req_valid, req_divided, req_divisor, hold, div_q, div_start_out,
        output req_ready, div_start, div_divided, div_divisor,
               rsp_valid, rsp_q, rsp_div0, rsp_ovf, err
    );

    modport master (
        output req_valid, req_divided, req_divisor, hold, div_q, div_start_out,
        input  req_ready, div_start, div_divided, div_divisor,
               rsp_valid, rsp_q, rsp_div0, rsp_ovf, err
    );

endinterface
`default_nettype wire

// File: rtl/div_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational one-hot round-robin grant with registered pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  wire logic                       clock,
    input  wire logic                       reset_n,
    input  wire logic [NUM_REQ-1:0]         i_valid,
    input  wire logic                       i_hold,
    output logic      [NUM_REQ-1:0]         o_grant,
    output logic      [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                            o_accept
);

    localparam int c_ptr_w = $clog2(NUM_REQ);

    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] w_id;
    logic               w_found;

    // Search ptr+1 .. ptr+NUM_REQ so the last winner has lowest priority.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_id    = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && !i_hold && i_valid[v_idx]) begin
                w_found = 1'b1;
                w_id    = c_ptr_w'(v_idx);
            end
        end
    end

    assign o_grant    = w_found ? (NUM_REQ'(1) << w_id) : '0;
    assign o_grant_id = w_id;
    assign o_accept   = w_found;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= c_ptr_w'(NUM_REQ - 1);
        end else if (w_found) begin
            r_ptr <= w_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter
// Purpose  : Shares one pipelined divider among NUM_REQ requesters, tagging
//            each operation so results return to their issuer.
//            Optional: DIV_ARB_ERR_CHECK_EN enables tag/strobe checking (err).
// Revision : 1.0 - initial release
// ============================================================================
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ = c_num_req_def,
    parameter int LATENCY = c_latency_def,
    parameter int Z_W     = c_z_w_def,
    parameter int D_W     = c_d_w_def,
    parameter int Q_W     = c_q_w_def
) (
    input wire logic     clock,
    input wire logic     reset_n,
    div_arbiter_if.slave bus
);

    localparam int c_ptr_w = $clog2(NUM_REQ);
    localparam int c_cmp_w = D_W + Z_W - Q_W;

    logic [NUM_REQ-1:0] w_grant;
    logic [c_ptr_w-1:0] w_grant_id;
    logic               w_accept;
    logic [Z_W-1:0]     w_sel_z;
    logic [D_W-1:0]     w_sel_d;
    tag_t               w_tag_in;
    tag_t               w_tag_out;
    logic               w_deliver;

    logic               r_div_start;
    logic [Z_W-1:0]     r_div_divided;
    logic [D_W-1:0]     r_div_divisor;
    tag_t               r_tag [LATENCY+1];
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [Q_W-1:0]     r_rsp_q;
    logic               r_rsp_div0;
    logic               r_rsp_ovf;
    logic               r_err;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_valid    (bus.req_valid),
        .i_hold     (bus.hold),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_accept   (w_accept)
    );

    assign bus.req_ready = w_grant;
    assign w_sel_z = bus.req_divided[int'(w_grant_id)*Z_W +: Z_W];
    assign w_sel_d = bus.req_divisor[int'(w_grant_id)*D_W +: D_W];

    // High dividend bits >= divisor means quotient >= 2^Q_W (and covers d==0).
    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = w_accept;
        w_tag_in.id    = c_id_w'(w_grant_id);
        w_tag_in.div0  = (w_sel_d == '0);
        w_tag_in.ovf   = (c_cmp_w'(w_sel_z[Z_W-1:Q_W]) >= c_cmp_w'(w_sel_d));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div_start   <= 1'b0;
            r_div_divided <= '0;
            r_div_divisor <= '0;
            r_tag[0]      <= '0;
        end else begin
            r_div_start <= w_accept;
            r_tag[0]    <= w_accept ? w_tag_in : '0;
            if (w_accept) begin
                r_div_divided <= w_sel_z;
                r_div_divisor <= w_sel_d;
            end
        end
    end

    // Stage 0 tracks the issue register; stage LATENCY meets div_start_out.
    for (genvar s = 1; s <= LATENCY; s++) begin : g_tag_stage
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_tag[s] <= '0;
            end else begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_tag_out = r_tag[LATENCY];

`ifdef DIV_ARB_ERR_CHECK_EN
    assign w_deliver = w_tag_out.valid & bus.div_start_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_tag_out.valid != bus.div_start_out) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_start_out;
    assign w_unused_start_out = bus.div_start_out;
    assign w_deliver          = w_tag_out.valid;
    assign r_err              = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= '0;
            r_rsp_q     <= '0;
            r_rsp_div0  <= 1'b0;
            r_rsp_ovf   <= 1'b0;
        end else if (w_deliver) begin
            r_rsp_valid <= NUM_REQ'(1) << w_tag_out.id;
            r_rsp_q     <= w_tag_out.div0 ? '1 : bus.div_q;
            r_rsp_div0  <= w_tag_out.div0;
            r_rsp_ovf   <= w_tag_out.ovf;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_q     <= '0;
            r_rsp_div0  <= 1'b0;
            r_rsp_ovf   <= 1'b0;
        end
    end

    assign bus.div_start   = r_div_start;
    assign bus.div_divided = r_div_divided;
    assign bus.div_divisor = r_div_divisor;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_q       = r_rsp_q;
    assign bus.rsp_div0    = r_rsp_div0;
    assign bus.rsp_ovf     = r_rsp_ovf;
    assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_arbiter
// Purpose  : Self-checking bench for div_arbiter with a behavioural divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LATENCY = 8;
    localparam int Z_W     = 28;
    localparam int D_W     = 20;
    localparam int Q_W     = 8;

    typedef struct {
        int             id;
        logic [Q_W-1:0] q;
        logic           div0;
        logic           ovf;
        int             due;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    exp_t sb[$];
    logic force_so = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    div_arbiter_if #(.NUM_REQ(NUM_REQ), .Z_W(Z_W), .D_W(D_W), .Q_W(Q_W)) bus ();

    div_arbiter #(
        .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .Z_W(Z_W), .D_W(D_W), .Q_W(Q_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural divider: LATENCY-deep pipe, truncated quotient.
    logic [LATENCY-1:0] m_start;
    logic [Q_W-1:0]     m_q [LATENCY];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_start <= '0;
        end else begin
            m_start <= {m_start[LATENCY-2:0], bus.div_start};
            m_q[0]  <= (bus.div_divisor == '0) ? '0 : Q_W'(bus.div_divided / Z_W'(bus.div_divisor));
            for (int k = 1; k < LATENCY; k++) m_q[k] <= m_q[k-1];
        end
    end

    assign bus.div_start_out = m_start[LATENCY-1] | force_so;
    assign bus.div_q         = m_q[LATENCY-1];

    // Scoreboard: push on acceptance, pop on response.
    always @(negedge clock) begin
        exp_t               e;
        logic [NUM_REQ-1:0] ev;
        longint             zq;
        logic [Z_W-1:0]     z;
        logic [D_W-1:0]     d;
        if (reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    z     = bus.req_divided[i*Z_W +: Z_W];
                    d     = bus.req_divisor[i*D_W +: D_W];
                    e.id  = i;
                    e.due = cyc + LATENCY + 2;
                    if (d == '0) begin
                        e.q = '1; e.div0 = 1'b1; e.ovf = 1'b1;
                    end else begin
                        zq     = longint'(z) / longint'(d);
                        e.q    = Q_W'(zq);
                        e.div0 = 1'b0;
                        e.ovf  = (zq >= (longint'(1) << Q_W));
                    end
                    sb.push_back(e);
                end
            end
            if (bus.rsp_valid != '0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding", bus.rsp_valid);
                end else begin
                    e  = sb.pop_front();
                    ev = NUM_REQ'(1) << e.id;
                    if (bus.rsp_valid !== ev) begin
                        bad++;
                        $display("FAIL rsp_route: got %b want %b", bus.rsp_valid, ev);
                    end
                    total++;
                    if (bus.rsp_q !== e.q) begin
                        bad++;
                        $display("FAIL rsp_q: got %0d want %0d", bus.rsp_q, e.q);
                    end
                    total++;
                    if ({bus.rsp_div0, bus.rsp_ovf} !== {e.div0, e.ovf}) begin
                        bad++;
                        $display("FAIL rsp_flags: got div0=%b ovf=%b want div0=%b ovf=%b",
                                 bus.rsp_div0, bus.rsp_ovf, e.div0, e.ovf);
                    end
                    total++;
                    if (cyc !== e.due) begin
                        bad++;
                        $display("FAIL rsp_latency: got cycle %0d want cycle %0d", cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic set_req(input int id, input logic [Z_W-1:0] z, input logic [D_W-1:0] d);
        bus.req_valid[id]               = 1'b1;
        bus.req_divided[id*Z_W +: Z_W]  = z;
        bus.req_divisor[id*D_W +: D_W]  = d;
    endtask

    task automatic issue(input int id, input logic [Z_W-1:0] z, input logic [D_W-1:0] d);
        bit got = 0;
        set_req(id, z, d);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            if (bus.req_ready[id]) got = 1;
        end
        step();
        bus.req_valid[id] = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL issue_timeout: req %0d got no grant, want grant within 20 cycles", id);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({bus.req_ready, bus.div_start, bus.div_divided, bus.div_divisor, bus.rsp_valid,
             bus.rsp_q, bus.rsp_div0, bus.rsp_ovf, bus.err} !== '0) begin
            bad++;
            $display("FAIL %s: ready=%b start=%b z=%0d d=%0d rv=%b q=%0d div0=%b ovf=%b err=%b want all 0",
                     tag, bus.req_ready, bus.div_start, bus.div_divided, bus.div_divisor,
                     bus.rsp_valid, bus.rsp_q, bus.rsp_div0, bus.rsp_ovf, bus.err);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        check_all_zero("reset_outputs");
        step();
        reset_n = 1'b1;
        @(negedge clock);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_grant_order();
        logic [NUM_REQ-1:0] want;
        step();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, Z_W'(100 * (i + 1) + 7), D_W'(i + 3));
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            want = NUM_REQ'(1) << (k % NUM_REQ);
            total++;
            if (bus.req_ready !== want) begin
                bad++;
                $display("FAIL grant_order[%0d]: got %b want %b", k, bus.req_ready, want);
            end
            if (k != 7) step();
        end
        step();
        bus.req_valid = '0;
        wait_drain();
    endtask

    task automatic test_single();
        issue(0, 28'd765, 20'd63);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [Z_W-1:0] zs [3];
        zs[0] = 28'd3315; zs[1] = 28'd5865; zs[2] = 28'd9180;
        for (int k = 0; k < 3; k++) begin
            set_req(1, zs[k], 20'd63);
            @(negedge clock);
            total++;
            if (bus.req_ready !== 4'b0010) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: got %b want 0010", k, bus.req_ready);
            end
            step();
        end
        bus.req_valid = '0;
        wait_drain();
    endtask

    task automatic test_boundary();
        issue(2, 28'd100, 20'd0);
        issue(2, 28'd16128, 20'd63);
        issue(2, 28'd16127, 20'd63);
        wait_drain();
    endtask

    task automatic test_hold();
        bus.hold = 1'b1;
        set_req(2, 28'd1000, 20'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            total++;
            if (bus.req_ready !== '0) begin
                bad++;
                $display("FAIL hold_ready[%0d]: got %b want 0000", k, bus.req_ready);
            end
            step();
        end
        bus.hold = 1'b0;
        @(negedge clock);
        total++;
        if (bus.req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL hold_release: got %b want 0100", bus.req_ready);
        end
        step();
        bus.req_valid = '0;
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        for (int k = 0; k < 3; k++) begin
            set_req(3, Z_W'(500 + k), 20'd5);
            step();
        end
        bus.req_valid = '0;
        step();
        reset_n = 1'b0;
        @(negedge clock);
        sb.delete();
        check_all_zero("midflight_reset_outputs");
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 2 * LATENCY + 4; k++) begin
            @(negedge clock);
            if (bus.rsp_valid != '0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midflight_discard: saw %0d responses want 0", seen);
        end
        check_all_zero("midflight_quiet");
        // Pointer back at NUM_REQ-1: requester 0 wins over 1.
        step();
        set_req(0, 28'd640, 20'd10);
        set_req(1, 28'd640, 20'd20);
        @(negedge clock);
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL ptr_after_reset: got %b want 0001", bus.req_ready);
        end
        step();
        bus.req_valid[0] = 1'b0;
        @(negedge clock);
        step();
        bus.req_valid = '0;
        wait_drain();
    endtask

    task automatic test_err();
`ifdef DIV_ARB_ERR_CHECK_EN
        step();
        force_so = 1'b1;
        step();
        force_so = 1'b0;
        @(negedge clock);
        total++;
        if (bus.err !== 1'b1) begin
            bad++;
            $display("FAIL err_set: got %b want 1", bus.err);
        end
        repeat (5) @(negedge clock);
        total++;
        if (bus.err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got %b want 1", bus.err);
        end
`else
        step();
        force_so = 1'b1;
        step();
        force_so = 1'b0;
        @(negedge clock);
        total++;
        if (bus.err !== 1'b0 || bus.rsp_valid !== '0) begin
            bad++;
            $display("FAIL err_disabled: err=%b rv=%b want 0 and 0000", bus.err, bus.rsp_valid);
        end
`endif
    endtask

    initial begin
        bus.req_valid   = '0;
        bus.req_divided = '0;
        bus.req_divisor = '0;
        bus.hold        = 1'b0;
        test_reset();
        test_grant_order();
        test_single();
        test_back_to_back();
        test_boundary();
        test_hold();
        test_reset_midflight();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one `pipeline_divider` among `NUM_REQ` requesters. It accepts one division request per cycle, issues it to the divider, and tracks each in-flight operation by requester ID through a tag pipeline. Each result is returned to the requester that issued it, with divide-by-zero and quotient-overflow flags. It sits between the datapath clients and the single divider instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `LATENCY`, 8: divider cycles from `start` to `StartOut`; must equal the instantiated divider's depth.
- `Z_W`, 28: dividend width.
- `D_W`, 20: divisor width.
- `Q_W`, 8: quotient width.
- `clock`  in  1: single clock; all logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester request.
- `req_ready`  out  NUM_REQ: one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `req_divided`  in  NUM_REQ*Z_W: packed dividends; requester i occupies slice i.
- `req_divisor`  in  NUM_REQ*D_W: packed divisors.
- `hold`  in  1: blocks all grants while high.
- `div_start`, `div_divided`, `div_divisor`  out  1/Z_W/D_W: registered drive to the divider.
- `div_q`  in  Q_W: divider quotient.
- `div_start_out`  in  1: divider result strobe.
- `rsp_valid`  out  NUM_REQ: one-hot, one-cycle result strobe.
- `rsp_q`  out  Q_W: quotient.
- `rsp_div0`  out  1: divisor was zero.
- `rsp_ovf`  out  1: true quotient exceeded `Q_W` bits.
- `err`  out  1: sticky tag/strobe mismatch flag.

## Operation
- Grant is combinational from `req_valid`, the round-robin pointer and `hold`.
  - Priority starts at `ptr+1` and wraps modulo `NUM_REQ`.
  - At most one bit of `req_ready` is high; all bits are 0 when `hold` is high or no request is pending.
- On acceptance of requester i:
  - The pointer moves to i.
  - The operands are registered to the `div_*` outputs with `div_start`=1.
  - A tag is pushed into a `LATENCY`-deep shift register: {valid, id, div0, ovf}.
  - div0 = (divisor==0).
  - ovf = (divided[Z_W-1:Q_W] >= divisor). This covers every quotient ≥ 2^Q_W; div0 implies ovf.
- With no acceptance, `div_start`=0 and an invalid tag is pushed. The operand registers hold their last value.
- At the tag-pipe output, when the tag is valid and `div_start_out` is high:
  - `rsp_valid[id]`=1 next cycle.
  - `rsp_q` = all-ones if div0, else `div_q`.
  - The flags are copied from the tag.
- Responses have no backpressure. Every requester must sink `rsp_valid` in the cycle it is asserted.
- Throughput is one operation per cycle; sustained back-to-back grants are legal.
- Reset value of every output is 0, and the pointer resets to `NUM_REQ-1` so that requester 0 has first priority. Reset mid-operation:
  - All tags are cleared and in-flight results are discarded.
  - `err` is cleared.
  - No `rsp_valid` occurs until a new request is accepted.
- `hold` rising while requests are pending leaves the pointer unchanged. Pending requests wait and are not dropped.

## Timing
- Acceptance edge at cycle t: `div_start` is high in cycle t+1.
- The tag matures in cycle t+1+LATENCY, aligned with `div_start_out`.
- `rsp_valid` is high in cycle t+2+LATENCY. Total latency is `LATENCY+2` cycles.
- Result order is issue order.
- `req_ready` changes only with `req_valid`, `hold` or the pointer; it has no combinational path from `div_*` inputs.

## Configuration
- `DIV_ARB_ERR_CHECK_EN` defined: `err` is set and held when the tag-pipe valid bit and `div_start_out` disagree in any cycle. `err` clears only on reset. A mismatched result is not delivered.
- `DIV_ARB_ERR_CHECK_EN` undefined: `err` is tied to 0. Responses are driven from tag valid alone, and `div_start_out` is ignored.

## Structure
- Package `div_arb_pkg` holds the default widths, `LATENCY`, and the tag struct typedef (valid, id, div0, ovf).
- Sub-module `rr_arbiter` holds the combinational one-hot round-robin grant and the pointer register. The top level holds the issue registers, the tag shift register and the response register.

## Test plan
- Single request: requester 0 sends z=765, d=63 → `rsp_valid`=0001 at t+LATENCY+2, `rsp_q`=12, no flags.
- Back-to-back from requester 1: z=3315, 5865, 9180 with d=63 on consecutive cycles → three consecutive responses with q=52, 93, 145, in order.
- All four requesters valid for 8 cycles → grant order 0,1,2,3,0,1,2,3. Each response is routed to the matching one-hot `rsp_valid`.
- Boundary operands:
  - d=0, z=100 → `rsp_div0`=1, `rsp_ovf`=1, `rsp_q`=8'hFF.
  - z=16128, d=63 → `rsp_ovf`=1.
  - z=16127, d=63 → q=255, `rsp_ovf`=0.
- `hold` high for 3 cycles with requester 2 pending → `req_ready`=0 throughout. Grant occurs on the first cycle after `hold` falls.
- `reset_n` pulsed low with 3 operations in flight → no `rsp_valid` afterwards and all outputs 0. With `DIV_ARB_ERR_CHECK_EN`, forcing `div_start_out` with no tag → `err`=1 and sticky.
